// File: rtl/sipo_rx_pkg.sv
// rtl/sipo_rx_pkg.sv - shared state encoding, line levels and counter sizing for the SIPO receiver
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

    localparam int DATA_W_DFLT = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DFLT = cnt_width(DATA_W_DFLT);

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - DATA_W-bit shift-left register, serial bit enters at the LSB
module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= {r_q[DATA_W-2:0], din};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - framed SIPO receive controller with one-entry valid/ready buffer
// Optional even-parity bit enabled by defining SIPO_RX_CTRL_PARITY_EN.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              serial_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = cnt_width(DATA_W);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_clear;
    logic              w_shift;
    logic              w_stop_chk;
    logic              w_par_bad;
    logic [DATA_W-1:0] w_shift_q;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_good;
    logic              w_bad;
    logic              w_accept;
    logic              w_load;

    sipo_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .shift_en (w_shift),
        .din      (serial_in),
        .q        (w_shift_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // enable low overrides every state so a partial frame never reaches STOP
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        w_stop_chk  = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_LVL) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                        w_clear     = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_cnt_nxt = '0;
`ifdef SIPO_RX_CTRL_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
`ifdef SIPO_RX_CTRL_PARITY_EN
                    w_state_nxt = ST_STOP;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
                ST_STOP: begin
                    w_stop_chk  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef SIPO_RX_CTRL_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (enable && r_state == ST_PARITY) begin
            r_par_err <= (^w_shift_q) ^ serial_in;
        end
    end

    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_good   = w_stop_chk && (serial_in == STOP_LVL) && !w_par_bad;
    assign w_bad    = w_stop_chk && !w_good;
    assign w_accept = r_out_valid && out_ready;
    assign w_load   = w_good && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= w_good && r_out_valid && !out_ready;
            if (w_load) begin
                r_out_data  <= w_shift_q;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb/tb_sipo_rx_ctrl.sv - directed self-checking bench for sipo_rx_ctrl
module tb_sipo_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       serial_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_vec;
    int n_err;

    sipo_rx_ctrl #(
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .serial_in (serial_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef SIPO_RX_CTRL_PARITY_EN
        send_bit(^d);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_body(d);
        send_bit(stop);
        serial_in = 1'b0;
    endtask

    initial begin
        logic [9:0] bits;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        enable    = 1'b1;
        serial_in = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovr", overrun, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        send_bit(1'b0);

        // basic receive: start, 8'hE8, stop
`ifndef SIPO_RX_CTRL_PARITY_EN
        bits = 10'b1111010000;
        for (int i = 9; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i > 0) begin
                check_val("basic_busy", busy, 1);
                check_val("basic_novalid", out_valid, 0);
            end
        end
        serial_in = 1'b0;
`else
        send_frame(8'hE8, 1'b0);
`endif
        check_val("basic_valid", out_valid, 1);
        check_val("basic_data", out_data, 8'hE8);
        check_val("basic_busy_end", busy, 0);
        send_bit(1'b0);
        check_val("basic_valid_1cyc", out_valid, 0);

        // bad stop bit
        send_frame(8'h3C, 1'b1);
        check_val("badstop_ferr", frame_err, 1);
        check_val("badstop_valid", out_valid, 0);
        send_bit(1'b0);
        check_val("badstop_ferr_pulse", frame_err, 0);

        // overrun with buffer full
        out_ready = 1'b0;
        send_frame(8'hE8, 1'b0);
        check_val("ovr_first_valid", out_valid, 1);
        check_val("ovr_first_ovr", overrun, 0);
        send_frame(8'h55, 1'b0);
        check_val("ovr_pulse", overrun, 1);
        check_val("ovr_keep_data", out_data, 8'hE8);
        check_val("ovr_keep_valid", out_valid, 1);
        send_bit(1'b0);
        check_val("ovr_pulse_end", overrun, 0);
        out_ready = 1'b1;
        send_bit(1'b0);
        check_val("ovr_drain", out_valid, 0);

        // same-edge accept and reload
        out_ready = 1'b0;
        send_frame(8'hE8, 1'b0);
        send_body(8'h55);
        out_ready = 1'b1;
        send_bit(1'b0);
        check_val("same_edge_data", out_data, 8'h55);
        check_val("same_edge_valid", out_valid, 1);
        check_val("same_edge_ovr", overrun, 0);
        send_bit(1'b0);
        check_val("same_edge_drain", out_valid, 0);

        // abort after data bit 4
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_val("abort_busy_pre", busy, 1);
        enable = 1'b0;
        send_bit(1'b0);
        check_val("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        check_val("abort_idle", busy, 0);
        check_val("abort_valid", out_valid, 0);
        check_val("abort_ferr", frame_err, 0);
        enable = 1'b1;
        send_bit(1'b0);
        send_frame(8'h81, 1'b0);
        check_val("abort_next_valid", out_valid, 1);
        check_val("abort_next_data", out_data, 8'h81);
        send_bit(1'b0);

        // asynchronous reset mid-frame with a full buffer
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_rst_valid", out_valid, 0);
        check_val("async_rst_data", out_data, 0);
        check_val("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        serial_in = 1'b0;
        send_bit(1'b0);
        send_frame(8'hA5, 1'b0);
        check_val("post_rst_valid", out_valid, 1);
        check_val("post_rst_data", out_data, 8'hA5);
        send_bit(1'b0);

`ifdef SIPO_RX_CTRL_PARITY_EN
        // 8'hB1 has four ones: even parity bit is 0
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(bits_b1(i));
        send_bit(1'b0);
        send_bit(1'b0);
        check_val("par_good_valid", out_valid, 1);
        check_val("par_good_data", out_data, 8'hB1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(bits_b1(i));
        send_bit(1'b1);
        send_bit(1'b0);
        check_val("par_bad_ferr", frame_err, 1);
        check_val("par_bad_valid", out_valid, 0);
        send_bit(1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic bits_b1(input int i);
        logic [7:0] v;
        v = 8'hB1;
        return v[i];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
